// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage.
// Opcode classes plus the enable/zero helpers used across the stage.
package id_stage_pkg;

    localparam logic [6:0] INST_TYPE_I     = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R     = 7'b0110011;
    localparam logic [6:0] INST_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] INST_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] INST_TYPE_L     = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S     = 7'b0100011;

    localparam logic [2:0] INST_SLLI = 3'b001;
    localparam logic [2:0] INST_SRI  = 3'b101;

    localparam logic [6:0] INST_F7_BASE = 7'b0000000;
    localparam logic [6:0] INST_F7_ALT  = 7'b0100000;

    localparam logic [31:0] ZeroWord    = 32'h0;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_I,
        CLS_R,
        CLS_LUI,
        CLS_AUIPC,
        CLS_L,
        CLS_S
    } inst_cls_t;

    function automatic inst_cls_t classify(input logic [6:0] opcode);
        inst_cls_t cls;
        cls = CLS_ILL;
        unique case (1'b1)
            (opcode == INST_TYPE_I):     cls = CLS_I;
            (opcode == INST_TYPE_R):     cls = CLS_R;
            (opcode == INST_TYPE_LUI):   cls = CLS_LUI;
            (opcode == INST_TYPE_AUIPC): cls = CLS_AUIPC;
            (opcode == INST_TYPE_L):     cls = CLS_L;
            (opcode == INST_TYPE_S):     cls = CLS_S;
            default:                     cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source select for one register read port.
// EX beats MEM beats register file; x0 and unread ports give zero.
module id_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              read,
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   data
);

    logic live;
    logic ex_hit;
    logic mem_hit;

    assign live    = read && (addr != '0);
    assign ex_hit  = (FWD_EN != 0) && live && ex_wen && (addr == ex_addr);
    assign mem_hit = (FWD_EN != 0) && live && mem_wen && (addr == mem_addr);

    // Youngest producer wins; x0 never forwards and always reads zero
    always_comb begin
        data = '0;
        if (ex_hit)
            data = ex_data;
        else if (mem_hit)
            data = mem_data;
        else if (live)
            data = rf_data;
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage with built-in ID/EX register.
// Handles forwarding, load-use bubbles, flush and downstream hold.
import id_stage_pkg::*;

module id_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       instaddr_i,
    input  logic              inst_valid_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic              rs1_read_o,
    output logic              rs2_read_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] ex_wr_addr_i,
    input  logic [XLEN-1:0]   ex_wr_data_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_wr_addr_i,
    input  logic [XLEN-1:0]   mem_wr_data_i,
    output logic              valid_o,
    output logic [31:0]       inst_o,
    output logic [31:0]       instaddr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic              regs_wen_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic              illegal_o
);

    inst_cls_t         cls;
    logic [4:0]        rs1_f;
    logic [4:0]        rs2_f;
    logic [4:0]        rd_f;
    logic [2:0]        f3;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   shamt;
    logic [XLEN-1:0]   pc;
    logic              rd1;
    logic              rd2;
    logic              wr;
    logic              ld;
    logic              st;
    logic              ill;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   store_data;
    logic              hazard;
    logic              last_load;
    logic [REG_AW-1:0] last_rd;

    function automatic logic out_of_range(input logic [4:0] idx);
        return int'(idx) >= (1 << REG_AW);
    endfunction

    assign cls   = classify(inst_i[6:0]);
    assign f3    = inst_i[14:12];
    assign rs1_f = inst_i[19:15];
    assign rs2_f = inst_i[24:20];
    assign rd_f  = inst_i[11:7];
    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign shamt = XLEN'(inst_i[24:20]);
    assign pc    = XLEN'(instaddr_i);

    // Per-class enables; illegal opcodes or registers kill every enable
    always_comb begin
        rd1 = 1'b0;
        rd2 = 1'b0;
        wr  = 1'b0;
        ld  = 1'b0;
        st  = 1'b0;
        ill = 1'b0;
        unique case (cls)
            CLS_I:     begin rd1 = ReadEnable; wr = WriteEnable; end
            CLS_R:     begin rd1 = ReadEnable; rd2 = ReadEnable; wr = WriteEnable; end
            CLS_LUI:   wr = WriteEnable;
            CLS_AUIPC: wr = WriteEnable;
            CLS_L:     begin rd1 = ReadEnable; wr = WriteEnable; ld = 1'b1; end
            CLS_S:     begin rd1 = ReadEnable; rd2 = ReadEnable; st = 1'b1; end
            default:   ill = 1'b1;
        endcase
        if ((rd1 && out_of_range(rs1_f)) || (rd2 && out_of_range(rs2_f)) ||
            (wr && out_of_range(rd_f)))
            ill = 1'b1;
        if (ill) begin
            rd1 = 1'b0;
            rd2 = 1'b0;
            wr  = 1'b0;
            ld  = 1'b0;
            st  = 1'b0;
        end
    end

    assign rs1_addr_o = rs1_f[REG_AW-1:0];
    assign rs2_addr_o = rs2_f[REG_AW-1:0];
    assign rs1_read_o = rd1;
    assign rs2_read_o = rd2;
    assign rd         = wr ? rd_f[REG_AW-1:0] : '0;

    id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
        .read     (rd1),
        .addr     (rs1_addr_o),
        .rf_data  (rs1_data_i),
        .ex_wen   (ex_wen_i),
        .ex_addr  (ex_wr_addr_i),
        .ex_data  (ex_wr_data_i),
        .mem_wen  (mem_wen_i),
        .mem_addr (mem_wr_addr_i),
        .mem_data (mem_wr_data_i),
        .data     (rs1_val)
    );

    id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
        .read     (rd2),
        .addr     (rs2_addr_o),
        .rf_data  (rs2_data_i),
        .ex_wen   (ex_wen_i),
        .ex_addr  (ex_wr_addr_i),
        .ex_data  (ex_wr_data_i),
        .mem_wen  (mem_wen_i),
        .mem_addr (mem_wr_addr_i),
        .mem_data (mem_wr_data_i),
        .data     (rs2_val)
    );

    // Operand assembly per instruction class
    always_comb begin
        op1 = '0;
        op2 = '0;
        unique case (cls)
            CLS_I: begin
                op1 = rs1_val;
                op2 = (f3 == INST_SLLI || f3 == INST_SRI) ? shamt : imm_i;
            end
            CLS_R:     begin op1 = rs1_val; op2 = rs2_val; end
            CLS_LUI:   op2 = imm_u;
            CLS_AUIPC: begin op1 = pc; op2 = imm_u; end
            CLS_L:     begin op1 = rs1_val; op2 = imm_i; end
            CLS_S:     begin op1 = rs1_val; op2 = imm_s; end
            default:   ;
        endcase
    end

    assign store_data = st ? rs2_val : '0;

    // A load now in EX cannot feed this instruction until it reaches MEM
    assign hazard = inst_valid_i && last_load && (last_rd != '0) &&
                    ((rd1 && rs1_addr_o == last_rd) ||
                     (rd2 && rs2_addr_o == last_rd));

    assign stall_o = hazard | hold_i;

    // ID/EX register: flush, then hold, then bubble, then normal load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o      <= 1'b0;
            inst_o       <= ZeroWord;
            instaddr_o   <= ZeroWord;
            op1_o        <= '0;
            op2_o        <= '0;
            store_data_o <= '0;
            regs_wen_o   <= 1'b0;
            rd_addr_o    <= '0;
            mem_ren_o    <= 1'b0;
            mem_wen_o    <= 1'b0;
            illegal_o    <= 1'b0;
            last_load    <= 1'b0;
            last_rd      <= '0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            regs_wen_o <= 1'b0;
            mem_ren_o  <= 1'b0;
            mem_wen_o  <= 1'b0;
            illegal_o  <= 1'b0;
            last_load  <= 1'b0;
        end else if (hold_i) begin
            valid_o <= valid_o;
        end else if (hazard) begin
            valid_o    <= 1'b0;
            regs_wen_o <= 1'b0;
            mem_ren_o  <= 1'b0;
            mem_wen_o  <= 1'b0;
            last_load  <= 1'b0;
        end else begin
            valid_o      <= inst_valid_i;
            inst_o       <= inst_i;
            instaddr_o   <= instaddr_i;
            op1_o        <= op1;
            op2_o        <= op2;
            store_data_o <= store_data;
            regs_wen_o   <= wr && inst_valid_i;
            rd_addr_o    <= rd;
            mem_ren_o    <= ld && inst_valid_i;
            mem_wen_o    <= st && inst_valid_i;
            illegal_o    <= ill && inst_valid_i;
            last_load    <= ld && inst_valid_i;
            last_rd      <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage (RV32I instance plus an RV32E instance).
// Expected ID/EX contents are queued at issue and popped when valid_o rises.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        wen;
        logic        ren;
        logic        mwen;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic        ivalid = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        ex_wen = 1'b0;
    logic [4:0]  ex_addr = '0;
    logic [31:0] ex_data = '0;
    logic        mem_wen = 1'b0;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] rf [32];

    logic        stall_o, rs1_read_o, rs2_read_o, valid_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] inst_o, instaddr_o, op1_o, op2_o, store_data_o;
    logic        regs_wen_o, mem_ren_o, mem_wen_o, illegal_o;

    logic        e_stall, e_rs1_read, e_rs2_read, e_valid;
    logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd_addr;
    logic [31:0] e_rs1_data, e_rs2_data;
    logic [31:0] e_inst, e_instaddr, e_op1, e_op2, e_store_data;
    logic        e_regs_wen, e_mem_ren, e_mem_wen, e_illegal;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    assign rs1_data   = rf[rs1_addr_o];
    assign rs2_data   = rf[rs2_addr_o];
    assign e_rs1_data = rf[{1'b0, e_rs1_addr}];
    assign e_rs2_data = rf[{1'b0, e_rs2_addr}];

    id_stage #(.XLEN(32), .REG_AW(5), .FWD_EN(1)) dut (
        .clk(clk), .rstn(rstn), .inst_i(inst), .instaddr_i(pc),
        .inst_valid_i(ivalid), .flush_i(flush), .hold_i(hold),
        .stall_o(stall_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_read_o(rs1_read_o), .rs2_read_o(rs2_read_o),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .ex_wen_i(ex_wen), .ex_wr_addr_i(ex_addr), .ex_wr_data_i(ex_data),
        .mem_wen_i(mem_wen), .mem_wr_addr_i(mem_addr), .mem_wr_data_i(mem_data),
        .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o),
        .op1_o(op1_o), .op2_o(op2_o), .store_data_o(store_data_o),
        .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o),
        .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .illegal_o(illegal_o)
    );

    id_stage #(.XLEN(32), .REG_AW(4), .FWD_EN(1)) dut_e (
        .clk(clk), .rstn(rstn), .inst_i(inst), .instaddr_i(pc),
        .inst_valid_i(ivalid), .flush_i(flush), .hold_i(hold),
        .stall_o(e_stall), .rs1_addr_o(e_rs1_addr), .rs2_addr_o(e_rs2_addr),
        .rs1_read_o(e_rs1_read), .rs2_read_o(e_rs2_read),
        .rs1_data_i(e_rs1_data), .rs2_data_i(e_rs2_data),
        .ex_wen_i(ex_wen), .ex_wr_addr_i(ex_addr[3:0]), .ex_wr_data_i(ex_data),
        .mem_wen_i(mem_wen), .mem_wr_addr_i(mem_addr[3:0]),
        .mem_wr_data_i(mem_data),
        .valid_o(e_valid), .inst_o(e_inst), .instaddr_o(e_instaddr),
        .op1_o(e_op1), .op2_o(e_op2), .store_data_o(e_store_data),
        .regs_wen_o(e_regs_wen), .rd_addr_o(e_rd_addr),
        .mem_ren_o(e_mem_ren), .mem_wen_o(e_mem_wen), .illegal_o(e_illegal)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
        input logic [31:0] sd, input logic [4:0] rd, input logic wen,
        input logic ren, input logic mwen, input logic ill);
        exp_t e;
        e = {op1, op2, sd, rd, wen, ren, mwen, ill};
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {op1_o, op2_o, store_data_o, rd_addr_o,
             regs_wen_o, mem_ren_o, mem_wen_o, illegal_o};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({valid_o, inst_o, instaddr_o, observed()} !== '0) begin
            failures++;
            $display("FAIL reset_regs got valid=%b obs=%h want 0", valid_o, observed());
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got %b want 0", stall_o);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_addi_fwd();
        inst = enc_i(12'hFFD, 5'd1, 3'b000, 5'd5, 7'h13);
        pc = 32'h40;
        ivalid = 1'b1;
        ex_wen = 1'b1; ex_addr = 5'd1; ex_data = 32'd10;
        sb.push_back(mk(32'd10, 32'hFFFF_FFFD, 0, 5'd5, 1, 0, 0, 0));
        tick();
        ivalid = 1'b0; ex_wen = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL addi_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL addi_fields got %h want %h", observed(), cur);
            end
        end
        checks++;
        if (instaddr_o !== 32'h40) begin
            failures++;
            $display("FAIL addi_pc got %h want 40", instaddr_o);
        end
    endtask

    task automatic test_x0();
        inst = enc_r(7'h00, 5'd2, 5'd0, 5'd3);
        ivalid = 1'b1;
        ex_wen = 1'b1; ex_addr = 5'd0; ex_data = 32'h55;
        sb.push_back(mk(32'd0, 32'd7, 0, 5'd3, 1, 0, 0, 0));
        tick();
        ivalid = 1'b0; ex_wen = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL x0_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL x0_fields got %h want %h", observed(), cur);
            end
        end
    endtask

    task automatic test_load_use();
        inst = enc_i(12'h000, 5'd1, 3'b010, 5'd4, 7'h03);
        ivalid = 1'b1;
        sb.push_back(mk(32'h101, 32'd0, 0, 5'd4, 1, 1, 0, 0));
        tick();
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL lw_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL lw_fields got %h want %h", observed(), cur);
            end
        end
        inst = enc_r(7'h00, 5'd4, 5'd4, 5'd6);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall got %b want 1", stall_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || regs_wen_o !== 1'b0 || mem_ren_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble got v=%b w=%b r=%b want 0", valid_o, regs_wen_o, mem_ren_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_release got %b want 0", stall_o);
        end
        mem_wen = 1'b1; mem_addr = 5'd4; mem_data = 32'h1234;
        sb.push_back(mk(32'h1234, 32'h1234, 0, 5'd6, 1, 0, 0, 0));
        tick();
        ivalid = 1'b0; mem_wen = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL lu_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL lu_fields got %h want %h", observed(), cur);
            end
        end
    endtask

    task automatic test_hold();
        inst = enc_s(12'd8, 5'd2, 5'd1);
        ivalid = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                failures++;
                $display("FAIL hold_stall got %b want 1", stall_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b1 || observed() !== cur) begin
                failures++;
                $display("FAIL hold_frozen got v=%b %h want 1 %h", valid_o, observed(), cur);
            end
        end
        hold = 1'b0;
        ex_wen = 1'b1; ex_addr = 5'd2; ex_data = 32'hCAFE;
        sb.push_back(mk(32'h101, 32'd8, 32'hCAFE, 5'd0, 0, 0, 1, 0));
        tick();
        ivalid = 1'b0; ex_wen = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL sw_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL sw_fields got %h want %h", observed(), cur);
            end
        end
    endtask

    task automatic test_flush_hold();
        inst = enc_i(12'd1, 5'd1, 3'b000, 5'd5, 7'h13);
        ivalid = 1'b1;
        flush = 1'b1;
        hold = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL fh_stall got %b want 1", stall_o);
        end
        tick();
        flush = 1'b0; hold = 1'b0; ivalid = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || regs_wen_o !== 1'b0 || mem_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL fh_kill got v=%b w=%b m=%b want 0", valid_o, regs_wen_o, mem_wen_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tab [5];
        tab[0] = enc_u(20'h12345, 5'd7, 7'h37);
        tab[1] = enc_u(20'hABCDE, 5'd8, 7'h17);
        tab[2] = enc_i({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd9, 7'h13);
        tab[3] = 32'h0000_007F;
        tab[4] = enc_r(7'h00, 5'd3, 5'd3, 5'd10);
        ex_wen = 1'b1; ex_addr = 5'd3; ex_data = 32'hE0;
        mem_wen = 1'b1; mem_addr = 5'd3; mem_data = 32'h3E0;
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst = tab[i];
            pc = 32'h100 + 32'(4 * i);
            unique case (i)
                0: sb.push_back(mk(0, 32'h1234_5000, 0, 5'd7, 1, 0, 0, 0));
                1: sb.push_back(mk(32'h104, 32'hABCD_E000, 0, 5'd8, 1, 0, 0, 0));
                2: sb.push_back(mk(32'h101, 32'd4, 0, 5'd9, 1, 0, 0, 0));
                3: sb.push_back(mk(0, 0, 0, 5'd0, 0, 0, 0, 1));
                default: sb.push_back(mk(32'hE0, 32'hE0, 0, 5'd10, 1, 0, 0, 0));
            endcase
            tick();
            checks++;
            if (valid_o !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL b2b_valid[%0d] got %b want 1", i, valid_o);
            end else begin
                cur = sb.pop_front();
                if (observed() !== cur) begin
                    failures++;
                    $display("FAIL b2b_fields[%0d] got %h want %h", i, observed(), cur);
                end
            end
        end
        ivalid = 1'b0; ex_wen = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic test_rv32e();
        inst = enc_i(12'd1, 5'd1, 3'b000, 5'd20, 7'h13);
        ivalid = 1'b1;
        sb.push_back(mk(32'h101, 32'd1, 0, 5'd20, 1, 0, 0, 0));
        tick();
        checks++;
        if (e_valid !== 1'b1 || e_illegal !== 1'b1 || e_regs_wen !== 1'b0) begin
            failures++;
            $display("FAIL rv32e_ill got v=%b ill=%b w=%b want 1 1 0", e_valid, e_illegal, e_regs_wen);
        end
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL rv32i_valid got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL rv32i_fields got %h want %h", observed(), cur);
            end
        end
        inst = enc_i(12'd1, 5'd1, 3'b000, 5'd5, 7'h13);
        sb.push_back(mk(32'h101, 32'd1, 0, 5'd5, 1, 0, 0, 0));
        tick();
        ivalid = 1'b0;
        checks++;
        if (e_illegal !== 1'b0 || e_regs_wen !== 1'b1 || e_rd_addr !== 4'd5 ||
            e_op1 !== 32'h101) begin
            failures++;
            $display("FAIL rv32e_ok got ill=%b w=%b rd=%h op1=%h want 0 1 5 101", e_illegal, e_regs_wen, e_rd_addr, e_op1);
        end
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL rv32i_valid2 got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL rv32i_fields2 got %h want %h", observed(), cur);
            end
        end
    endtask

    task automatic test_reset_mid_hazard();
        inst = enc_i(12'h000, 5'd1, 3'b010, 5'd4, 7'h03);
        ivalid = 1'b1;
        sb.push_back(mk(32'h101, 32'd0, 0, 5'd4, 1, 1, 0, 0));
        tick();
        checks++;
        if (valid_o !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL rmh_lw got %b want 1", valid_o);
        end else begin
            cur = sb.pop_front();
            if (observed() !== cur) begin
                failures++;
                $display("FAIL rmh_lw_fields got %h want %h", observed(), cur);
            end
        end
        inst = enc_r(7'h00, 5'd4, 5'd4, 5'd6);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL rmh_stall got %b want 1", stall_o);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({valid_o, inst_o, instaddr_o, observed(), stall_o} !== '0) begin
            failures++;
            $display("FAIL rmh_clear got v=%b obs=%h stall=%b want 0", valid_o, observed(), stall_o);
        end
        ivalid = 1'b0;
        rstn = 1'b1;
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf[i] = 32'h100 + 32'(i);
        rf[0] = 32'hDEAD_BEEF;
        rf[2] = 32'd7;
        test_reset();
        test_addi_fwd();
        test_x0();
        test_load_use();
        test_hold();
        test_flush_hold();
        test_back_to_back();
        test_rv32e();
        test_reset_mid_hazard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
